// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for pipe_stage_skid: upstream valid/ready/data, downstream
// valid/ready/data and the live-entry count. The stage uses the slave side.
interface pipe_stage_skid_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, optional two-entry skid
// buffer (registered in_ready), synchronous flush and a bubble value on idle.
module pipe_stage_skid #(
  parameter int unsigned      WIDTH  = 64,
  parameter bit               SKID   = 1'b1,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 flush,
  pipe_stage_skid_if.slave     bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             rdy_q;
  logic             vld_q;

  logic in_ready;
  logic accept;
  logic consume;

  // Without the skid buffer the stage can only take a new entry when the held
  // one leaves this same cycle, so FULL is never reached and rdy_q goes unused.
  assign in_ready = SKID ? rdy_q : (~vld_q | bus.out_ready);
  assign accept   = bus.in_valid & in_ready;
  assign consume  = vld_q & bus.out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
    end else if (flush) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q <= ONE;
            main_q  <= bus.in_data;
            vld_q   <= 1'b1;
          end
        end
        ONE: begin
          if (accept && !consume) begin
            state_q <= FULL;
            skid_q  <= bus.in_data;
            rdy_q   <= 1'b0;
          end else if (accept && consume) begin
            main_q  <= bus.in_data;
          end else if (consume) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE;
            vld_q   <= 1'b0;
          end
        end
        FULL: begin
          if (consume) begin
            state_q <= ONE;
            main_q  <= skid_q;
            skid_q  <= BUBBLE;
            rdy_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= EMPTY;
          main_q  <= BUBBLE;
          skid_q  <= BUBBLE;
          rdy_q   <= 1'b1;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  // main_q is forced to BUBBLE whenever it empties, so it drives out_data directly.
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_q;
  assign bus.out_data  = main_q;
  assign bus.occupancy = state_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: one SKID=1 instance (BUBBLE 0) and one SKID=0
// instance (BUBBLE 0x13), checked against queue scoreboards.
module tb_pipe_stage_skid;
  localparam int unsigned W = 16;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  logic flush_a = 1'b0;
  logic flush_b = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  pipe_stage_skid_if #(.WIDTH(W)) if_a ();
  pipe_stage_skid_if #(.WIDTH(W)) if_b ();

  pipe_stage_skid #(.WIDTH(W), .SKID(1'b1), .BUBBLE(16'h0000)) dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush_a),
    .bus     (if_a)
  );

  pipe_stage_skid #(.WIDTH(W), .SKID(1'b0), .BUBBLE(16'h0013)) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush_b),
    .bus     (if_b)
  );

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];

  // Values sampled on the falling edge preceding each rising edge.
  logic         a_acc, a_con, a_ir, a_ov, a_fl, a_ordy;
  logic [W-1:0] a_od, a_exp;
  logic [1:0]   a_occ;
  int           a_n;
  logic         b_acc, b_con, b_ir, b_ov, b_fl, b_ordy;
  logic [W-1:0] b_od, b_exp;
  logic [1:0]   b_occ;
  int           b_n;

  task automatic tick();
    @(negedge clock);
    a_ir = if_a.in_ready; a_ov = if_a.out_valid; a_od = if_a.out_data;
    a_occ = if_a.occupancy; a_n = qa.size(); a_fl = flush_a; a_ordy = if_a.out_ready;
    a_acc = if_a.in_valid && a_ir; a_con = a_ov && a_ordy; a_exp = 'x;
    if (a_fl) qa.delete();
    else begin
      if (a_con && qa.size() > 0) a_exp = qa.pop_front();
      if (a_acc) qa.push_back(if_a.in_data);
    end
    b_ir = if_b.in_ready; b_ov = if_b.out_valid; b_od = if_b.out_data;
    b_occ = if_b.occupancy; b_n = qb.size(); b_fl = flush_b; b_ordy = if_b.out_ready;
    b_acc = if_b.in_valid && b_ir; b_con = b_ov && b_ordy; b_exp = 'x;
    if (b_fl) qb.delete();
    else begin
      if (b_con && qb.size() > 0) b_exp = qb.pop_front();
      if (b_acc) qb.push_back(if_b.in_data);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    if_a.in_valid = 1'b0; if_a.in_data = '0; if_a.out_ready = 1'b0;
    if_b.in_valid = 1'b0; if_b.in_data = '0; if_b.out_ready = 1'b0;
    flush_a = 1'b0; flush_b = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 reset_n = 1'b0;
    #1;
    tests++; if (if_a.out_valid !== 1'b0) begin fails++; $display("FAIL reset_a_valid got %b want 0", if_a.out_valid); end
    tests++; if (if_a.occupancy !== 2'd0) begin fails++; $display("FAIL reset_a_occ got %0d want 0", if_a.occupancy); end
    tests++; if (if_a.in_ready !== 1'b1) begin fails++; $display("FAIL reset_a_ready got %b want 1", if_a.in_ready); end
    tests++; if (if_a.out_data !== 16'h0000) begin fails++; $display("FAIL reset_a_data got %h want 0000", if_a.out_data); end
    tests++; if (if_b.in_ready !== 1'b1) begin fails++; $display("FAIL reset_b_ready got %b want 1", if_b.in_ready); end
    tests++; if (if_b.out_data !== 16'h0013) begin fails++; $display("FAIL reset_b_data got %h want 0013", if_b.out_data); end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_streaming();
    if_a.out_ready = 1'b1; if_b.out_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      if_a.in_valid = (i <= 8); if_a.in_data = 16'(i);
      if_b.in_valid = (i <= 8); if_b.in_data = 16'(i);
      tick();
      if (i <= 8) begin
        tests++; if (a_ir !== 1'b1) begin fails++; $display("FAIL stream_a_ready[%0d] got %b want 1", i, a_ir); end
        tests++; if (b_ir !== 1'b1) begin fails++; $display("FAIL stream_b_ready[%0d] got %b want 1", i, b_ir); end
      end
      if (i >= 2) begin
        tests++; if (a_con !== 1'b1 || a_od !== 16'(i - 1)) begin
          fails++; $display("FAIL stream_a_out[%0d] got valid=%b data=%h want valid=1 data=%h", i, a_con, a_od, 16'(i - 1));
        end
        tests++; if (b_con !== 1'b1 || b_od !== b_exp) begin
          fails++; $display("FAIL stream_b_out[%0d] got valid=%b data=%h want valid=1 data=%h", i, b_con, b_od, b_exp);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_bubble();
    idle_inputs();
    tick();
    tests++; if (if_b.out_valid !== 1'b0 || if_b.out_data !== 16'h0013) begin
      fails++; $display("FAIL bubble_b got valid=%b data=%h want valid=0 data=0013", if_b.out_valid, if_b.out_data);
    end
    tests++; if (if_a.out_data !== 16'h0000) begin fails++; $display("FAIL bubble_a got %h want 0000", if_a.out_data); end
  endtask

  task automatic test_backpressure();
    idle_inputs();
    if_a.in_valid = 1'b1; if_a.in_data = 16'h000A; tick();
    tests++; if (a_acc !== 1'b1) begin fails++; $display("FAIL bp_acc_A got %b want 1", a_acc); end
    if_a.in_data = 16'h000B; tick();
    tests++; if (a_acc !== 1'b1) begin fails++; $display("FAIL bp_acc_B got %b want 1", a_acc); end
    if_a.in_data = 16'h000C; tick();
    tests++; if (a_ir !== 1'b0) begin fails++; $display("FAIL bp_ready_full got %b want 0", a_ir); end
    tests++; if (a_occ !== 2'd2) begin fails++; $display("FAIL bp_occ got %0d want 2", a_occ); end
    if_a.out_ready = 1'b1; tick();
    tests++; if (a_con !== 1'b1 || a_od !== 16'h000A || a_acc !== 1'b0) begin
      fails++; $display("FAIL bp_first got con=%b acc=%b data=%h want con=1 acc=0 data=000a", a_con, a_acc, a_od);
    end
    tick();
    tests++; if (a_ir !== 1'b1) begin fails++; $display("FAIL bp_ready_back got %b want 1", a_ir); end
    tests++; if (a_con !== 1'b1 || a_od !== 16'h000B) begin fails++; $display("FAIL bp_second got con=%b data=%h want 000b", a_con, a_od); end
    if_a.in_valid = 1'b0; tick();
    tests++; if (a_con !== 1'b1 || a_od !== 16'h000C) begin fails++; $display("FAIL bp_third got con=%b data=%h want 000c", a_con, a_od); end
    tick();
    tests++; if (a_ov !== 1'b0) begin fails++; $display("FAIL bp_drained got valid=%b want 0", a_ov); end
    idle_inputs();
  endtask

  task automatic test_flush();
    idle_inputs();
    if_a.in_valid = 1'b1; if_a.in_data = 16'h0021; tick();
    if_a.in_data = 16'h0022; tick();
    if_a.in_data = 16'h0023; flush_a = 1'b1; tick();
    flush_a = 1'b0; if_a.in_valid = 1'b0;
    tests++; if (if_a.occupancy !== 2'd0 || if_a.out_valid !== 1'b0 || if_a.out_data !== 16'h0000) begin
      fails++; $display("FAIL flush_state got occ=%0d valid=%b data=%h want occ=0 valid=0 data=0000",
                        if_a.occupancy, if_a.out_valid, if_a.out_data);
    end
    tests++; if (if_a.in_ready !== 1'b1) begin fails++; $display("FAIL flush_ready got %b want 1", if_a.in_ready); end
    if_a.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (a_ov !== 1'b0) begin fails++; $display("FAIL flush_no_output[%0d] got valid=%b data=%h want none", i, a_ov, a_od); end
    end
    idle_inputs();
  endtask

  task automatic test_skid0();
    idle_inputs();
    if_b.in_valid = 1'b1; if_b.in_data = 16'h0031; tick();
    if_b.in_data = 16'h0032;
    #1;
    tests++; if (if_b.in_ready !== 1'b0) begin fails++; $display("FAIL skid0_ready_held got %b want 0", if_b.in_ready); end
    tests++; if (if_b.occupancy !== 2'd1) begin fails++; $display("FAIL skid0_occ got %0d want 1", if_b.occupancy); end
    if_b.out_ready = 1'b1;
    #1;
    tests++; if (if_b.in_ready !== 1'b1) begin fails++; $display("FAIL skid0_ready_comb got %b want 1", if_b.in_ready); end
    tick();
    tests++; if (b_con !== 1'b1 || b_acc !== 1'b1 || b_od !== 16'h0031) begin
      fails++; $display("FAIL skid0_replace got con=%b acc=%b data=%h want con=1 acc=1 data=0031", b_con, b_acc, b_od);
    end
    if_b.in_valid = 1'b0; tick();
    tests++; if (b_con !== 1'b1 || b_od !== 16'h0032) begin fails++; $display("FAIL skid0_second got con=%b data=%h want 0032", b_con, b_od); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] cnt;
    cnt = 16'h0100;
    idle_inputs();
    for (int i = 0; i < 300; i++) begin
      if_a.in_valid = ($urandom_range(0, 3) != 0); if_a.in_data = cnt;
      if_b.in_valid = ($urandom_range(0, 3) != 0); if_b.in_data = cnt ^ 16'h8000;
      if_a.out_ready = ($urandom_range(0, 2) != 0);
      if_b.out_ready = ($urandom_range(0, 2) != 0);
      flush_a = (i > 250) ? 1'b0 : ($urandom_range(0, 31) == 0);
      flush_b = (i > 250) ? 1'b0 : ($urandom_range(0, 31) == 0);
      if (i >= 280) begin if_a.in_valid = 1'b0; if_b.in_valid = 1'b0; if_a.out_ready = 1'b1; if_b.out_ready = 1'b1; end
      cnt = cnt + 16'd1;
      tick();
      tests++; if (a_occ !== 2'(a_n) || a_ov !== (a_n > 0) || a_ir !== (a_n < 2)) begin
        fails++; $display("FAIL b2b_a_state[%0d] got occ=%0d valid=%b ready=%b want occ=%0d", i, a_occ, a_ov, a_ir, a_n);
      end
      tests++; if (b_occ !== 2'(b_n) || b_ov !== (b_n > 0) || b_ir !== (b_n == 0 || b_ordy)) begin
        fails++; $display("FAIL b2b_b_state[%0d] got occ=%0d valid=%b ready=%b want occ=%0d", i, b_occ, b_ov, b_ir, b_n);
      end
      if (a_con && !a_fl) begin
        tests++; if (a_od !== a_exp) begin fails++; $display("FAIL b2b_a_data[%0d] got %h want %h", i, a_od, a_exp); end
      end
      if (b_con && !b_fl) begin
        tests++; if (b_od !== b_exp) begin fails++; $display("FAIL b2b_b_data[%0d] got %h want %h", i, b_od, b_exp); end
      end
      if (!a_ov) begin
        tests++; if (a_od !== 16'h0000) begin fails++; $display("FAIL b2b_a_bubble[%0d] got %h want 0000", i, a_od); end
      end
      if (!b_ov) begin
        tests++; if (b_od !== 16'h0013) begin fails++; $display("FAIL b2b_b_bubble[%0d] got %h want 0013", i, b_od); end
      end
    end
    tests++; if (qa.size() != 0 || qb.size() != 0) begin
      fails++; $display("FAIL b2b_drain got left_a=%0d left_b=%0d want 0", qa.size(), qb.size());
    end
    idle_inputs();
  endtask

  task automatic test_reset_midstream();
    idle_inputs();
    if_a.in_valid = 1'b1; if_a.in_data = 16'h0041; tick();
    if_a.in_data = 16'h0042; tick();
    if_a.in_valid = 1'b0;
    tests++; if (if_a.occupancy !== 2'd2) begin fails++; $display("FAIL rst_mid_pre_occ got %0d want 2", if_a.occupancy); end
    #1 reset_n = 1'b0;
    #1;
    tests++; if (if_a.occupancy !== 2'd0 || if_a.out_valid !== 1'b0 || if_a.out_data !== 16'h0000 || if_a.in_ready !== 1'b1) begin
      fails++; $display("FAIL rst_mid got occ=%0d valid=%b data=%h ready=%b want occ=0 valid=0 data=0000 ready=1",
                        if_a.occupancy, if_a.out_valid, if_a.out_data, if_a.in_ready);
    end
    qa.delete(); qb.delete();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    if_a.out_ready = 1'b1;
    tick();
    tests++; if (a_ov !== 1'b0) begin fails++; $display("FAIL rst_mid_after got valid=%b data=%h want none", a_ov, a_od); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_bubble();
    test_backpressure();
    test_flush();
    test_skid0();
    test_back_to_back();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register that replaces the fixed-width, stall-vector-driven stage latches between pipeline stages. It carries an arbitrary-width payload with a valid/ready handshake, an optional two-entry skid buffer that registers the upstream ready, and a synchronous flush. Invalid slots present a configurable bubble value on the data output. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- WIDTH, 64, payload width in bits (for example PC plus instruction).
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- BUBBLE, {WIDTH{1'b0}}, value driven on out_data whenever out_valid = 0.

- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  stage can accept this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a live entry.
- out_ready  input  1  downstream consumes this cycle.
- out_data  output  WIDTH  head entry, or BUBBLE when not valid.
- occupancy  output  2  number of live entries (0..2; max 1 when SKID = 0).

## Operation
- Accept = in_valid & in_ready; consume = out_valid & out_ready.
- Storage: main register (head), plus skid register when SKID = 1.
- State machine (SKID = 1):
  - EMPTY: accept -> ONE, main takes in_data.
  - ONE:
    - accept without consume -> FULL, skid takes in_data.
    - accept with consume -> ONE, main takes in_data.
    - consume only -> EMPTY.
    - neither -> hold.
  - FULL:
    - consume -> ONE, main takes skid contents, skid cleared.
    - no consume -> hold.
    - No accept is possible in FULL because in_ready = 0.
- in_ready (SKID = 1) = state != FULL, taken from a register. There is no combinational path from out_ready.
- SKID = 0:
  - Single register.
  - in_ready = !out_valid | out_ready (combinational).
  - On accept, the register loads in_data; on consume without accept, it empties.
- flush:
  - Next state is EMPTY and both data registers load BUBBLE, regardless of accept or consume that cycle.
  - An input offered during flush is dropped. It counts as accepted for upstream bookkeeping only if in_ready was 1; upstream flushes in the same cycle.
- out_data = main register when out_valid, else BUBBLE. The main register is forced to BUBBLE when it empties.
- Ordering is strictly FIFO; no entry is ever duplicated or dropped except by flush.
- occupancy = 0/1/2 for EMPTY/ONE/FULL.

## Timing
- Reset (reset_n low, asynchronous):
  - State EMPTY.
  - out_valid = 0, out_data = BUBBLE, occupancy = 0.
  - in_ready = 1 in both SKID modes.
  - Skid register = BUBBLE.
- Reset release is synchronised by the integrator. The block resumes on the first rising edge with reset_n high.
- Reset mid-transfer discards all entries with no partial update.
- Latency: data accepted at edge N is visible on out_data with out_valid = 1 after edge N.
- Throughput: one transfer per cycle in steady state with out_ready held high, in both modes.
- SKID = 1: in_ready falls the cycle after the stage becomes FULL and rises the cycle after the first consume from FULL.
- Simultaneous accept and consume in ONE keeps occupancy at 1 with no bubble.
- flush has priority over every other event. Reset has priority over flush.
- out_valid, out_data, in_ready (SKID = 1) and occupancy are all register outputs.

## Test plan
- Reset: hold reset_n = 0 mid-stream with two entries held -> outputs go to reset values immediately, without waiting for a clock edge; occupancy = 0, out_data = BUBBLE.
- Streaming: out_ready = 1, inject 0x1..0x8 back-to-back -> same sequence on out_data, each one cycle later, no gaps, in_ready constantly 1.
- Backpressure (SKID = 1): out_ready = 0, inject 0xA, 0xB, 0xC ->
  - 0xA and 0xB are accepted.
  - in_ready = 0 while 0xC is presented.
  - occupancy = 2.
  - After out_ready = 1: 0xA, 0xB, 0xC emerge in order, and in_ready returns to 1 one cycle after 0xA is consumed.
- Flush while FULL with in_valid = 1 -> next cycle occupancy = 0, out_valid = 0, out_data = BUBBLE; the flushed input never appears.
- Bubble value: BUBBLE = 0x13 (NOP), idle input -> out_data = 0x13 while out_valid = 0.
- SKID = 0: out_ready = 0 with one held entry -> in_ready = 0 in the same cycle; asserting out_ready raises in_ready combinationally and allows a simultaneous replace.
